// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline register.
// The optional stall counter is enabled by defining PIPE_STAGE_PERF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_WIDTH  = 32;
    localparam int PIPE_CTRL_W = 6;
    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage register: a loadable register that
// synchronously resets to zero.
module pipe_slot #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer and flush.
// Defining PIPE_STAGE_PERF_EN adds a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH  = PIPE_WIDTH,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int SLOT_W = WIDTH + CTRL_W;

    pipe_state_e       state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              skid_load;
    logic [SLOT_W-1:0] in_entry;
    logic [SLOT_W-1:0] main_d;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;
    assign in_entry = {in_ctrl, in_data};

    // Flush suppresses loads; slot contents are don't-care once the state is EMPTY.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: main_load = in_fire;
                ST_BUSY: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & ~out_fire;
                end
                ST_FULL: begin
                    main_load = out_fire;
                    main_d    = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ST_BUSY;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    pipe_slot #(.W(SLOT_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_load),
        .data_i (main_d),
        .data_o (main_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .data_i (in_entry),
        .data_o (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q[WIDTH-1:0];
    assign out_ctrl  = out_valid_q ? main_q[SLOT_W-1:WIDTH] : '0;

`ifdef PIPE_STAGE_PERF_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Counts cycles where downstream refuses a valid entry; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random run
// against a queue-based model. Honours PIPE_STAGE_PERF_EN for the counter.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_ctrl;
    logic [31:0] stall_count;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: entries held by the stage, head first (capacity two).
    logic [37:0] mq[$];
    logic [31:0] stallExp = 32'd0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .stall_count (stall_count)
    );

    function automatic logic [5:0] ctrlOf(input logic [31:0] d);
        return d[5:0] ^ 6'h2A;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctrlOf(d);
    endtask

    // Advance one clock and apply the stage's rules to the model queue.
    task automatic tick();
        bit inF;
        bit outF;
        inF  = in_valid && (mq.size() < 2);
        outF = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            stallExp = 32'd0;
        end else begin
`ifdef PIPE_STAGE_PERF_EN
            if (mq.size() > 0 && !out_ready && !flush && stallExp != 32'hFFFF_FFFF)
                stallExp = stallExp + 32'd1;
`endif
            if (outF) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (inF) mq.push_back({in_ctrl, in_data});
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nErrors++;
            $display("FAIL reset_hs: out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
        end
        nChecks++;
        if (out_ctrl !== 6'd0 || out_data !== 32'd0 || stall_count !== 32'd0) begin
            nErrors++;
            $display("FAIL reset_vals: out_ctrl=%h out_data=%h stall=%0d, want 0/0/0",
                     out_ctrl, out_data, stall_count);
        end
        reset = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0055);
        tick();
        drive(1'b0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nChecks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_ctrl !== 6'd0) begin
            nErrors++;
            $display("FAIL reset_mid: out_valid=%0b out_data=%h out_ctrl=%h, want 0/0/0",
                     out_valid, out_data, out_ctrl);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals = '{32'h1, 32'h2, 32'h3};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i]);
            tick();
            nChecks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || out_ctrl !== ctrlOf(vals[i])
                || in_ready !== 1'b1) begin
                nErrors++;
                $display("FAIL stream_%0d: v=%0b data=%h ctrl=%h rdy=%0b, want 1/%h/%h/1",
                         i, out_valid, out_data, out_ctrl, in_ready, vals[i], ctrlOf(vals[i]));
            end
        end
        drive(1'b0, 32'd0);
        tick();
        nChecks++;
        if (out_valid !== 1'b0 || out_ctrl !== 6'd0) begin
            nErrors++;
            $display("FAIL stream_drain: out_valid=%0b out_ctrl=%h, want 0/0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_stall();
        logic [31:0] expOut [3];
        expOut = '{32'hA, 32'hB, 32'hC};
        out_ready = 1'b0;
        drive(1'b1, 32'hA);
        tick();
        drive(1'b1, 32'hB);
        tick();
        drive(1'b1, 32'hC);
        tick();
        nChecks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0) begin
            nErrors++;
            $display("FAIL stall_full: v=%0b data=%h rdy=%0b, want 1/a/0", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            nChecks++;
            if (out_valid !== 1'b1 || out_data !== expOut[i] || in_ready !== 1'b1) begin
                nErrors++;
                $display("FAIL stall_release_%0d: v=%0b data=%h rdy=%0b, want 1/%h/1",
                         i, out_valid, out_data, in_ready, expOut[i]);
            end
        end
        drive(1'b0, 32'd0);
        tick();
        nChecks++;
        if (out_valid !== 1'b0) begin
            nErrors++;
            $display("FAIL stall_drain: out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h11);
        tick();
        drive(1'b1, 32'h12);
        tick();
        drive(1'b1, 32'hD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++;
        if (out_valid !== 1'b0 || out_ctrl !== 6'd0 || in_ready !== 1'b1) begin
            nErrors++;
            $display("FAIL flush_full: v=%0b ctrl=%h rdy=%0b, want 0/0/1", out_valid, out_ctrl, in_ready);
        end
        drive(1'b0, 32'd0);
        out_ready = 1'b1;
        tick();
        nChecks++;
        if (out_valid !== 1'b0) begin
            nErrors++;
            $display("FAIL flush_no_d: out_valid=%0b data=%h, want 0", out_valid, out_data);
        end
        drive(1'b1, 32'h21);
        tick();
        drive(1'b1, 32'h22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        tick();
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nErrors++;
            $display("FAIL flush_busy: v=%0b rdy=%0b data=%h, want 0/1", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_counter();
        logic [31:0] want;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h44);
        tick();
        drive(1'b0, 32'd0);
        repeat (5) tick();
`ifdef PIPE_STAGE_PERF_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        nChecks++;
        if (stall_count !== want) begin
            nErrors++;
            $display("FAIL counter_5: stall_count=%0d, want %0d", stall_count, want);
        end
        out_ready = 1'b1;
        tick();
        tick();
        nChecks++;
        if (stall_count !== want || out_valid !== 1'b0) begin
            nErrors++;
            $display("FAIL counter_hold: stall_count=%0d v=%0b, want %0d/0", stall_count, out_valid, want);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 32'h6);
        tick();
        drive(1'b1, 32'h7);
        tick();
        nChecks++;
        if (out_valid !== 1'b1 || out_data !== 32'h7 || in_ready !== 1'b1 || out_ctrl !== ctrlOf(32'h7)) begin
            nErrors++;
            $display("FAIL simul_fire: v=%0b data=%h rdy=%0b ctrl=%h, want 1/7/1/%h",
                     out_valid, out_data, in_ready, out_ctrl, ctrlOf(32'h7));
        end
        drive(1'b0, 32'd0);
        tick();
        nChecks++;
        if (out_valid !== 1'b0) begin
            nErrors++;
            $display("FAIL simul_drain: out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        bit          expValid;
        bit          expReady;
        logic [37:0] head;
        for (int cyc = 0; cyc < 600; cyc++) begin
            expValid = mq.size() > 0;
            expReady = mq.size() < 2;
            head     = expValid ? mq[0] : 38'd0;
            nChecks++;
            if (out_valid !== expValid || in_ready !== expReady) begin
                nErrors++;
                $display("FAIL rnd_hs@%0d: v=%0b rdy=%0b, want %0b/%0b",
                         cyc, out_valid, in_ready, expValid, expReady);
            end
            nChecks++;
            if (out_ctrl !== head[37:32] || (expValid && out_data !== head[31:0])) begin
                nErrors++;
                $display("FAIL rnd_data@%0d: data=%h ctrl=%h, want %h/%h",
                         cyc, out_data, out_ctrl, head[31:0], head[37:32]);
            end
            nChecks++;
            if (stall_count !== stallExp) begin
                nErrors++;
                $display("FAIL rnd_count@%0d: stall_count=%0d, want %0d", cyc, stall_count, stallExp);
            end
            if (!(in_valid && !expReady)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = $urandom;
                in_ctrl  = 6'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0);
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_counter();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
